// File: rtl/pe_pkg.sv
// Shared constants, vector types and the saturation helper for the processing element.
// The helper is only referenced when PE_ACC_SAT_EN is defined.
package pe_pkg;

  localparam int PE_WIDTH     = 8;
  localparam int PE_ACC_WIDTH = 2 * PE_WIDTH;

  typedef logic [PE_WIDTH-1:0]     operand_t;
  typedef logic [PE_ACC_WIDTH-1:0] acc_t;

  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_HI   = 2'd1,
    SAT_LO   = 2'd2
  } sat_e;

  // Classifies a same-width add from its sign bits and carry, so it works for any accumulator width.
  function automatic sat_e sat_code(
    input logic acc_msb,
    input logic add_msb,
    input logic sum_msb,
    input logic carry,
    input logic is_signed
  );
    sat_e code;
    code = SAT_NONE;
    if (is_signed) begin
      if ((acc_msb == add_msb) && (sum_msb != acc_msb)) begin
        code = acc_msb ? SAT_LO : SAT_HI;
      end
    end else if (carry) begin
      code = SAT_HI;
    end
    return code;
  endfunction

endpackage

// File: rtl/pe_if.sv
// Handshake/data bundle between a processing element and its driver or neighbours.
interface pe_if
  import pe_pkg::*;
#(
  parameter int WIDTH     = PE_WIDTH,
  parameter int ACC_WIDTH = 2 * WIDTH
);

  logic                 EN;
  logic                 CLR;
  logic [WIDTH-1:0]     Input;
  logic [WIDTH-1:0]     Weight;
  logic [WIDTH-1:0]     ToRight;
  logic [WIDTH-1:0]     ToDown;
  logic [ACC_WIDTH-1:0] Result;

  modport master (
    output EN,
    output CLR,
    output Input,
    output Weight,
    input  ToRight,
    input  ToDown,
    input  Result
  );

  modport slave (
    input  EN,
    input  CLR,
    input  Input,
    input  Weight,
    output ToRight,
    output ToDown,
    output Result
  );

endinterface

// File: rtl/pe_mac.sv
// Combinational multiply, extend and accumulate for one processing element.
// With PE_ACC_SAT_EN defined the add clamps at the accumulator rails instead of wrapping.
module pe_mac
  import pe_pkg::*;
#(
  parameter int WIDTH     = PE_WIDTH,
  parameter int ACC_WIDTH = 2 * WIDTH,
  parameter int SIGNED    = 0
) (
  input  logic [WIDTH-1:0]     act,
  input  logic [WIDTH-1:0]     weight,
  input  logic [ACC_WIDTH-1:0] acc,
  output logic [ACC_WIDTH-1:0] acc_next
);

  logic [ACC_WIDTH-1:0] prod_ext;

  // Full-width product, then sign- or zero-extension to the accumulator width.
  if (SIGNED != 0) begin : g_signed
    logic signed [2*WIDTH-1:0] prod;
    assign prod     = (2*WIDTH)'($signed(act)) * (2*WIDTH)'($signed(weight));
    assign prod_ext = ACC_WIDTH'(prod);
  end else begin : g_unsigned
    logic [2*WIDTH-1:0] prod;
    assign prod     = (2*WIDTH)'(act) * (2*WIDTH)'(weight);
    assign prod_ext = ACC_WIDTH'(prod);
  end

`ifdef PE_ACC_SAT_EN
  localparam logic [ACC_WIDTH-1:0] ACC_HI = (SIGNED != 0) ?
    {1'b0, {(ACC_WIDTH-1){1'b1}}} : {ACC_WIDTH{1'b1}};
  localparam logic [ACC_WIDTH-1:0] ACC_LO = (SIGNED != 0) ?
    {1'b1, {(ACC_WIDTH-1){1'b0}}} : {ACC_WIDTH{1'b0}};

  logic [ACC_WIDTH:0] sum_c;
  sat_e               sat;

  assign sum_c = {1'b0, acc} + {1'b0, prod_ext};
  assign sat   = sat_code(acc[ACC_WIDTH-1], prod_ext[ACC_WIDTH-1], sum_c[ACC_WIDTH-1],
                          sum_c[ACC_WIDTH], SIGNED != 0);

  always_comb begin
    case (sat)
      SAT_HI:  acc_next = ACC_HI;
      SAT_LO:  acc_next = ACC_LO;
      default: acc_next = sum_c[ACC_WIDTH-1:0];
    endcase
  end
`else
  assign acc_next = acc + prod_ext;
`endif

endmodule

// File: rtl/processing_element.sv
// Output-stationary MAC cell: forwards activation right, weight down, accumulates their product.
// Define PE_ACC_SAT_EN to make the accumulator saturate instead of wrapping.
module processing_element
  import pe_pkg::*;
#(
  parameter int WIDTH     = PE_WIDTH,
  parameter int ACC_WIDTH = 2 * WIDTH,
  parameter int SIGNED    = 0
) (
  input  logic CLK,
  input  logic SYNC_RST,
  pe_if.slave  bus
);

  logic [WIDTH-1:0]     to_right;
  logic [WIDTH-1:0]     to_down;
  logic [ACC_WIDTH-1:0] result;
  logic [ACC_WIDTH-1:0] acc_next;

  pe_mac #(
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .SIGNED    (SIGNED)
  ) u_mac (
    .act      (bus.Input),
    .weight   (bus.Weight),
    .acc      (result),
    .acc_next (acc_next)
  );

  // Single register stage; priority is reset > clear > enable > hold.
  always_ff @(posedge CLK) begin
    if (!SYNC_RST) begin
      to_right <= '0;
      to_down  <= '0;
      result   <= '0;
    end else begin
      if (bus.EN) begin
        to_right <= bus.Input;
        to_down  <= bus.Weight;
      end
      if (bus.CLR) begin
        result <= '0;
      end else if (bus.EN) begin
        result <= acc_next;
      end
    end
  end

  assign bus.ToRight = to_right;
  assign bus.ToDown  = to_down;
  assign bus.Result  = result;

endmodule

// File: tb/tb_processing_element.sv
// Randomised and directed bench for processing_element; an unsigned and a signed cell share stimulus.
// The reference model follows PE_ACC_SAT_EN when the bench is built with it.
module tb_processing_element;
  import pe_pkg::*;

  localparam int W  = 8;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pe_if #(.WIDTH(W), .ACC_WIDTH(AW)) bus_u ();
  pe_if #(.WIDTH(W), .ACC_WIDTH(AW)) bus_s ();

  processing_element #(.WIDTH(W), .ACC_WIDTH(AW), .SIGNED(0)) dut_u (
    .CLK      (clk),
    .SYNC_RST (rst),
    .bus      (bus_u)
  );

  processing_element #(.WIDTH(W), .ACC_WIDTH(AW), .SIGNED(1)) dut_s (
    .CLK      (clk),
    .SYNC_RST (rst),
    .bus      (bus_s)
  );

  int     checks = 0;
  int     errors = 0;
  longint exp_res [2];
  int     exp_tr;
  int     exp_td;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Operand value as a plain integer under the given signedness.
  function automatic longint opnd(input int v, input bit sgn);
    return (sgn && v >= 128) ? longint'(v - 256) : longint'(v);
  endfunction

  // Brings an ideal sum back into the accumulator's representable range.
  function automatic longint settle(input longint s, input bit sgn);
    longint m;
    longint span = longint'(1) << AW;
`ifdef PE_ACC_SAT_EN
    longint hi = sgn ? span / 2 - 1 : span - 1;
    longint lo = sgn ? -(span / 2) : 0;
    m = (s > hi) ? hi : ((s < lo) ? lo : s);
`else
    m = s % span;
    if (m < 0) m += span;
    if (sgn && m >= span / 2) m -= span;
`endif
    return m;
  endfunction

  function automatic logic [63:0] pat(input longint v);
    return 64'(v & ((longint'(1) << AW) - 1));
  endfunction

  task automatic cycle(input bit rst_n, input bit en, input bit clr, input int a, input int b);
    rst          = rst_n;
    bus_u.EN     = en;
    bus_s.EN     = en;
    bus_u.CLR    = clr;
    bus_s.CLR    = clr;
    bus_u.Input  = W'(a);
    bus_s.Input  = W'(a);
    bus_u.Weight = W'(b);
    bus_s.Weight = W'(b);
    @(posedge clk);
    if (!rst_n) begin
      exp_res[0] = 0;
      exp_res[1] = 0;
      exp_tr     = 0;
      exp_td     = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (clr) exp_res[k] = 0;
        else if (en) exp_res[k] = settle(exp_res[k] + opnd(a, k[0]) * opnd(b, k[0]), k[0]);
      end
      if (en) begin
        exp_tr = a;
        exp_td = b;
      end
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, "/u.right"}, 64'(bus_u.ToRight), 64'(exp_tr));
    check({tag, "/u.down"},  64'(bus_u.ToDown),  64'(exp_td));
    check({tag, "/u.res"},   64'(bus_u.Result),  pat(exp_res[0]));
    check({tag, "/s.right"}, 64'(bus_s.ToRight), 64'(exp_tr));
    check({tag, "/s.down"},  64'(bus_s.ToDown),  64'(exp_td));
    check({tag, "/s.res"},   64'(bus_s.Result),  pat(exp_res[1]));
  endtask

  bit r_n, en_r, clr_r;
  int a_r, b_r;

  initial begin
    exp_res[0] = 0;
    exp_res[1] = 0;
    exp_tr     = 0;
    exp_td     = 0;

    cycle(0, 0, 0, 0, 0);
    check("rst.res", 64'(bus_u.Result), 64'd0);
    check("rst.right", 64'(bus_u.ToRight), 64'd0);
    check_all("rst");

    cycle(1, 1, 0, 5, 3);
    check("mac1.right", 64'(bus_u.ToRight), 64'd5);
    check("mac1.down", 64'(bus_u.ToDown), 64'd3);
    check("mac1.res", 64'(bus_u.Result), 64'd15);
    cycle(1, 1, 0, 7, 2);
    check("mac2.right", 64'(bus_u.ToRight), 64'd7);
    check("mac2.down", 64'(bus_u.ToDown), 64'd2);
    check("mac2.res", 64'(bus_u.Result), 64'd29);

    repeat (3) begin
      cycle(1, 0, 0, 9, 9);
      check("hold.right", 64'(bus_u.ToRight), 64'd7);
      check("hold.res", 64'(bus_u.Result), 64'd29);
      check_all("hold");
    end

    cycle(1, 1, 1, 4, 4);
    check("clr.res", 64'(bus_u.Result), 64'd0);
    check("clr.right", 64'(bus_u.ToRight), 64'd4);
    check("clr.down", 64'(bus_u.ToDown), 64'd4);
    cycle(1, 1, 0, 2, 3);
    check("postclr.res", 64'(bus_u.Result), 64'd6);

    cycle(1, 0, 1, 0, 0);
    cycle(1, 1, 0, 5, 3);
    cycle(1, 1, 0, 7, 2);
    check("pre_rst.res", 64'(bus_u.Result), 64'd29);
    cycle(0, 1, 0, 6, 6);
    check("midrst.res", 64'(bus_u.Result), 64'd0);
    check("midrst.right", 64'(bus_u.ToRight), 64'd0);
    check("midrst.down", 64'(bus_s.ToDown), 64'd0);
    cycle(1, 1, 0, 1, 1);
    check("postrst.res", 64'(bus_u.Result), 64'd1);

    cycle(1, 0, 1, 0, 0);
    cycle(1, 1, 0, 255, 255);
    cycle(1, 1, 0, 255, 255);
`ifdef PE_ACC_SAT_EN
    check("ovf.res", 64'(bus_u.Result), 64'd65535);
`else
    check("ovf.res", 64'(bus_u.Result), 64'd64514);
`endif
    check_all("ovf");

    cycle(1, 0, 1, 0, 0);
    cycle(1, 1, 0, 8'hFD, 4);
    check("sgn1.res", 64'(bus_s.Result), 64'h0000_0000_0000_FFF4);
    cycle(1, 1, 0, 5, 5);
    check("sgn2.res", 64'(bus_s.Result), 64'd13);

    cycle(1, 0, 1, 0, 0);
    repeat (3) begin
      cycle(1, 1, 0, 128, 128);
      check_all("sgn_ext");
    end

    for (int i = 0; i < 400; i++) begin
      r_n   = ($urandom_range(63) != 0);
      en_r  = ($urandom_range(3) != 0);
      clr_r = ($urandom_range(15) == 0);
      a_r   = ($urandom_range(3) == 0) ? (($urandom_range(1) == 0) ? 255 : 128)
                                       : int'($urandom_range(255));
      b_r   = ($urandom_range(3) == 0) ? (($urandom_range(1) == 0) ? 255 : 128)
                                       : int'($urandom_range(255));
      cycle(r_n, en_r, clr_r, a_r, b_r);
      check_all("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
